// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
// State encoding, wait-counter sizing and byte-lane count.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam int WAIT_MAX  = 15;
    localparam int CNT_WIDTH = 4;
    localparam int BE_WIDTH  = 4;

    // True when a byte address is misaligned or beyond the array.
    function automatic logic addr_err(
        input logic [31:0] a,
        input int          aw
    );
        return (a[1:0] != 2'b00) || ((a >> (aw + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Word RAM: synchronous write with byte lanes, combinational read.
// Contents are never reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [BE_WIDTH-1:0]   be,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Commit the enabled byte lanes of a store.
    always_ff @(posedge clk) begin
        if (wen) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Bus responder: accepts one word request, waits, answers with ready.
// Optional per-byte store enables under macro BYTE_WRITE_EN.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [31:0]           adr,
    input  logic [DATA_WIDTH-1:0] wdata,
`ifdef BYTE_WRITE_EN
    input  logic [BE_WIDTH-1:0]   be,
`endif
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ready,
    output logic                  err,
    output logic                  busy
);

    state_t                state;
    state_t                state_nxt;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [31:0]           cap_adr;
    logic                  cap_we;
    logic [DATA_WIDTH-1:0] cap_wdata;
    logic [BE_WIDTH-1:0]   cap_be;
    logic [BE_WIDTH-1:0]   in_be;

    logic                  accept;
    logic                  enter_resp;
    logic [31:0]           sel_adr;
    logic                  sel_we;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [BE_WIDTH-1:0]   sel_be;
    logic                  sel_err;
    logic [ADDR_WIDTH-1:0] index;
    logic                  mem_wen;
    logic [DATA_WIDTH-1:0] mem_rdata;

`ifdef BYTE_WRITE_EN
    assign in_be = be;
`else
    assign in_be = {BE_WIDTH{1'b1}};
`endif

    assign accept     = (state == IDLE) && req;
    assign enter_resp = (state_nxt == RESP) && (state != RESP);

    // With zero wait states RESP is entered on the accept edge itself,
    // so the live inputs stand in for the not-yet-captured ones.
    assign sel_adr   = (state == IDLE) ? adr   : cap_adr;
    assign sel_we    = (state == IDLE) ? we    : cap_we;
    assign sel_wdata = (state == IDLE) ? wdata : cap_wdata;
    assign sel_be    = (state == IDLE) ? in_be : cap_be;

    assign sel_err = addr_err(sel_adr, ADDR_WIDTH);
    assign index   = sel_adr[ADDR_WIDTH+1:2];
    assign mem_wen = enter_resp && sel_we && !sel_err;

    mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk   (clk),
        .wen   (mem_wen),
        .addr  (index),
        .wdata (sel_wdata),
        .be    (sel_be),
        .rdata (mem_rdata)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == CNT_WIDTH'(1)) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Wait-state counter: load on accept, count down in WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CNT_WIDTH'(WAIT_CYCLES);
        end else if (state == WAIT) begin
            cnt <= cnt - CNT_WIDTH'(1);
        end
    end

    // Capture the request fields at accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_adr   <= '0;
            cap_we    <= 1'b0;
            cap_wdata <= '0;
            cap_be    <= '0;
        end else if (accept) begin
            cap_adr   <= adr;
            cap_we    <= we;
            cap_wdata <= wdata;
            cap_be    <= in_be;
        end
    end

    // Registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            ready <= enter_resp;
            err   <= enter_resp && sel_err;
            busy  <= (state_nxt != IDLE);
        end
    end

    // Read data: loaded by good reads, zeroed by errors, kept by stores.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (enter_resp) begin
            if (sel_err) begin
                rdata <= '0;
            end else if (!sel_we) begin
                rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: two instances,
// two wait states and zero wait states.
module tb_mem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    logic        clk;
    logic        reset;

    logic        req0, we0, req1, we1;
    logic [31:0] adr0, wdata0, adr1, wdata1;
    logic [3:0]  be0, be1;
    logic [31:0] rdata0, rdata1;
    logic        ready0, err0, busy0;
    logic        ready1, err1, busy1;

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int fails  = 0;
    int bcnt0  = 0;
    int bcnt1  = 0;
    int rcnt1  = 0;

    mem_responder #(
        .ADDR_WIDTH  (10),
        .WAIT_CYCLES (2),
        .DATA_WIDTH  (32)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .req   (req0),
        .we    (we0),
        .adr   (adr0),
        .wdata (wdata0),
`ifdef BYTE_WRITE_EN
        .be    (be0),
`endif
        .rdata (rdata0),
        .ready (ready0),
        .err   (err0),
        .busy  (busy0)
    );

    mem_responder #(
        .ADDR_WIDTH  (10),
        .WAIT_CYCLES (0),
        .DATA_WIDTH  (32)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .req   (req1),
        .we    (we1),
        .adr   (adr1),
        .wdata (wdata1),
`ifdef BYTE_WRITE_EN
        .be    (be1),
`endif
        .rdata (rdata1),
        .ready (ready1),
        .err   (err1),
        .busy  (busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Monitor for dut0: pop and compare on every ready pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                bcnt0 = 0;
            end else begin
                if (busy0) bcnt0++;
                if (ready0) begin
                    if (q0.size() == 0) begin
                        chk("d0 unexpected ready", 32'd1, 32'd0);
                    end else begin
                        e = q0.pop_front();
                        chk({e.name, " rdata"}, rdata0, e.rdata);
                        chk({e.name, " err"}, {31'd0, err0}, {31'd0, e.err});
                        chk({e.name, " busy cycles"}, bcnt0, 32'd3);
                    end
                    bcnt0 = 0;
                end
            end
        end
    end

    // Monitor for dut1.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                bcnt1 = 0;
            end else begin
                if (busy1) bcnt1++;
                if (ready1) begin
                    rcnt1++;
                    if (q1.size() == 0) begin
                        chk("d1 unexpected ready", 32'd1, 32'd0);
                    end else begin
                        e = q1.pop_front();
                        chk({e.name, " rdata"}, rdata1, e.rdata);
                        chk({e.name, " err"}, {31'd0, err1}, {31'd0, e.err});
                        chk({e.name, " busy cycles"}, bcnt1, 32'd1);
                    end
                    bcnt1 = 0;
                end
            end
        end
    end

    task automatic txn0(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] er,
                        input logic ee, input string nm);
        exp_t e;
        int   n;
        @(negedge clk);
        req0 = 1'b1; we0 = w; adr0 = a; wdata0 = d;
        e.rdata = er; e.err = ee; e.name = nm;
        q0.push_back(e);
        @(negedge clk);
        req0 = 1'b0;
        n = 0;
        while (!ready0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready0) chk({nm, " timeout"}, 32'd0, 32'd1);
    endtask

    task automatic txn1(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        input logic [31:0] er, input logic ee,
                        input string nm);
        exp_t e;
        int   n;
        @(negedge clk);
        req1 = 1'b1; we1 = w; adr1 = a; wdata1 = d; be1 = b;
        e.rdata = er; e.err = ee; e.name = nm;
        q1.push_back(e);
        @(negedge clk);
        req1 = 1'b0;
        n = 0;
        while (!ready1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready1) chk({nm, " timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        reset = 1'b0;
        req0 = 0; we0 = 0; adr0 = 0; wdata0 = 0; be0 = 4'hF;
        req1 = 0; we1 = 0; adr1 = 0; wdata1 = 0; be1 = 4'hF;
        repeat (3) @(negedge clk);
        chk("reset ready", {31'd0, ready0}, 32'd0);
        chk("reset busy", {31'd0, busy0}, 32'd0);
        chk("reset err", {31'd0, err0}, 32'd0);
        chk("reset rdata", rdata0, 32'd0);
        reset = 1'b1;

        txn0(1, 32'h14, 32'hDEADBEEF, 32'h0, 0, "preload a5");
        txn0(0, 32'h14, 32'h0, 32'hDEADBEEF, 0, "read a5");
        txn0(1, 32'h20, 32'h12345678, 32'hDEADBEEF, 0, "store 20");
        txn0(0, 32'h20, 32'h0, 32'h12345678, 0, "read 20");
        txn0(1, 32'h22, 32'h55555555, 32'h0, 1, "misaligned st");
        txn0(0, 32'h20, 32'h0, 32'h12345678, 0, "reread 20");
        txn0(0, 32'h1000, 32'h0, 32'h0, 1, "out of range");
        txn0(1, 32'hFFC, 32'h0F0F0F0F, 32'h0, 0, "store top");
        txn0(0, 32'hFFC, 32'h0, 32'h0F0F0F0F, 0, "read top");
        txn0(1, 32'h30, 32'hCAFEF00D, 32'h0F0F0F0F, 0, "store 30");
        txn0(0, 32'h30, 32'h0, 32'hCAFEF00D, 0, "read 30");

        // Abort a store during WAIT.
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; adr0 = 32'h30; wdata0 = 32'h0BADBAD0;
        @(negedge clk);
        req0 = 1'b0;
        chk("abort busy before", {31'd0, busy0}, 32'd1);
        reset = 1'b0;
        #1;
        chk("abort ready", {31'd0, ready0}, 32'd0);
        chk("abort busy", {31'd0, busy0}, 32'd0);
        chk("abort rdata", rdata0, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        txn0(0, 32'h30, 32'h0, 32'hCAFEF00D, 0, "after abort 30");
        txn0(0, 32'h14, 32'h0, 32'hDEADBEEF, 0, "after abort a5");

        // Zero-wait instance.
        txn1(1, 32'h8, 32'hA5A5A5A5, 4'hF, 32'h0, 0, "z store 8");
        rcnt1 = 0;
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b0; adr1 = 32'h8;
        e.rdata = 32'hA5A5A5A5; e.err = 1'b0; e.name = "b2b first";
        q1.push_back(e);
        e.name = "b2b second";
        q1.push_back(e);
        repeat (4) @(negedge clk);
        req1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b responses", rcnt1, 32'd2);

`ifdef BYTE_WRITE_EN
        txn1(1, 32'h0, 32'h0, 4'hF, 32'hA5A5A5A5, 0, "be clear");
        txn1(1, 32'h0, 32'hAABBCCDD, 4'b0010, 32'hA5A5A5A5, 0, "be lane1");
        txn1(0, 32'h0, 32'h0, 4'hF, 32'h0000CC00, 0, "be read");
        txn1(1, 32'h0, 32'hFFFFFFFF, 4'b0000, 32'h0000CC00, 0, "be none");
        txn1(0, 32'h0, 32'h0, 4'hF, 32'h0000CC00, 0, "be reread");
`endif

        repeat (5) @(negedge clk);
        chk("q0 drained", q0.size(), 32'd0);
        chk("q1 drained", q1.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle ARM core's unified instruction/data bus. The core initiates; this block answers.
- Accepts one word request at a time: a fetch, a load or a store.
- Inserts a configurable number of wait states, then returns read data with a one-cycle ready pulse.
- Holds a local word-addressed RAM array and flags misaligned or out-of-range accesses.

Parameters:
- ADDR_WIDTH, 10, word-address bits; array depth is 2^ADDR_WIDTH words.
- WAIT_CYCLES, 2, wait states between accept and response; legal range 0..15.
- DATA_WIDTH, 32, word width; fixed at 32.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  request strobe, sampled only in IDLE.
- we  in  1  1 = store, 0 = read (fetch or load).
- adr  in  32  byte address.
- wdata  in  32  store data.
- rdata  out  32  read data; valid when ready=1 and we was 0.
- ready  out  1  one-cycle completion pulse.
- err  out  1  error qualifier; meaningful only while ready=1.
- busy  out  1  high from accept until the response cycle, inclusive.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - ready=0, err=0, busy=0, rdata=0, wait counter=0.
  - Array contents are not cleared.
  - Reset mid-transaction aborts it; no write is committed.
- Outputs: all registered; none is combinational from the inputs.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On a clock edge with req=1: capture adr, we and wdata into internal registers; set busy=1.
  - If WAIT_CYCLES=0, go to RESP; otherwise load the counter with WAIT_CYCLES and go to WAIT.
  - If req=0, stay in IDLE.
- WAIT:
  - Decrement the counter every cycle.
  - Go to RESP on the edge where the counter goes from 1 to 0.
  - Input changes are ignored; the captured values are used.
- RESP (exactly one cycle):
  - ready=1, busy=1.
  - Next state is always IDLE, where ready=0 and busy=0.
- Latency: accept edge to ready high is WAIT_CYCLES+1 cycles.
- Throughput: a new request can be accepted no earlier than the IDLE cycle after RESP.
- Requester contract: drop req after sampling ready. req still high in IDLE is a new request.
- Address decode:
  - Word index is adr[ADDR_WIDTH+1:2].
  - Error if adr[1:0]!=0 or adr[31:ADDR_WIDTH+2]!=0.
- Error response: err=1 with ready; no array write; rdata=0.
- Good read: rdata = array[index] in RESP. rdata holds that value until the next read response or reset.
- Good store:
  - The array word is written on the edge that enters RESP.
  - rdata is left unchanged.
  - A read issued immediately after returns the new value.
- Unused captured fields are don't-care.

Optional Feature:
- Macro: BYTE_WRITE_EN.
- With the macro defined:
  - Adds input port be, 4 bits, captured with the request.
  - A store writes only the byte lanes with be[i]=1, bit i → wdata[8i+7:8i].
  - be=0000 completes with ready and no change.
  - Misalignment is still checked on adr[1:0].
- Without the macro: no be port; every store writes the full word.

Decomposition:
- Shared package mem_pkg:
  - State encoding typedef: IDLE=2'b00, WAIT=2'b01, RESP=2'b10.
  - WAIT_CYCLES maximum constant (15).
  - Counter width constant (4).
- Natural sub-module: mem_array, a synchronous-write, combinational-read word RAM with ADDR_WIDTH and optional byte enables.
- The FSM, counter and decode stay in mem_responder.

Test Plan:
- Read latency: preload array[5]=32'hDEADBEEF, WAIT_CYCLES=2; req=1, we=0, adr=32'h14.
  - → ready high exactly 3 cycles after accept, rdata=32'hDEADBEEF, err=0, busy high for 3 cycles.
- Store then read: store wdata=32'h12345678 to adr=32'h20, then read adr=32'h20.
  - → second response rdata=32'h12345678; rdata unchanged during the store response.
- Misaligned: store to adr=32'h22.
  - → ready with err=1, rdata=0; a later read of adr=32'h20 returns the prior value.
- Out of range, ADDR_WIDTH=10: read adr=32'h00001000.
  - → err=1, rdata=0.
- Reset mid-operation: assert reset=0 during WAIT of a store to adr=32'h30.
  - → immediately ready=0, busy=0, rdata=0; array[12] unchanged; the next request is served normally.
- Zero-wait and back-to-back, WAIT_CYCLES=0: req held high for 4 cycles.
  - → ready one cycle after each accept; accepts alternate IDLE/RESP, giving 2 responses in 4 cycles.
  - With BYTE_WRITE_EN: be=4'b0010, wdata=32'hAABBCCDD onto 32'h00000000 → word reads 32'h0000CC00.
